// File: rtl/wallace_dot_accum.sv
// Accumulates up to NTERMS unsigned products into one AW-bit dot-product result on a valid/ready output.
// Optional feature: define WALLACE_ACC_SAT_EN to saturate on carry instead of wrapping.
module wallace_dot_accum #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int NTERMS = 8,
    localparam int CW = $clog2(NTERMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prod_valid,
    output logic          prod_ready,
    input  logic [PW-1:0] prod_data,
    input  logic          prod_last,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data,
    output logic [CW-1:0] res_count,
    output logic          res_ovf
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          res_valid_q, res_valid_d;
    logic [AW-1:0] res_data_q, res_data_d;
    logic [CW-1:0] res_count_q, res_count_d;
    logic          res_ovf_q, res_ovf_d;

    logic [AW:0]   sum_ext;
    logic          carry;
    logic [AW-1:0] acc_new;
    logic [CW-1:0] cnt_inc;
    logic          ovf_new;
    logic          accept;
    logic          close_res;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;

        // The first term of a result overwrites the stale sum, so no clear cycle is needed.
        if (cnt_q == '0) begin
            sum_ext = (AW + 1)'(prod_data);
        end else begin
            sum_ext = {1'b0, acc_q} + (AW + 1)'(prod_data);
        end
        carry = sum_ext[AW];
`ifdef WALLACE_ACC_SAT_EN
        acc_new = carry ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
        acc_new = sum_ext[AW-1:0];
`endif
        ovf_new   = ovf_q | carry;
        cnt_inc   = cnt_q + CW'(1);
        accept    = prod_valid && (state_q == ACCUM);
        close_res = prod_last || (cnt_inc == CW'(NTERMS));

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_new;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_new;
                    if (close_res) begin
                        state_d     = DONE;
                        res_valid_d = 1'b1;
                        res_data_d  = acc_new;
                        res_count_d = cnt_inc;
                        res_ovf_d   = ovf_new;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = ACCUM;
                    res_valid_d = 1'b0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign prod_ready = (state_q == ACCUM);
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_count  = res_count_q;
    assign res_ovf    = res_ovf_q;

endmodule

// File: tb/tb_wallace_dot_accum.sv
// Directed, table-driven bench for wallace_dot_accum: a default instance plus a narrow AW=16, NTERMS=2 instance for overflow.
module tb_wallace_dot_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic [15:0] prod_data = '0;
    logic        prod_last = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [23:0] res_data;
    logic [3:0]  res_count;
    logic        res_ovf;

    logic        p2_valid = 1'b0;
    logic        p2_ready;
    logic [15:0] p2_data = '0;
    logic        p2_last = 1'b0;
    logic        r2_valid;
    logic        r2_ready = 1'b0;
    logic [15:0] r2_data;
    logic [1:0]  r2_count;
    logic        r2_ovf;

    int checks = 0;
    int failures = 0;
    int hs = 0;

    wallace_dot_accum #(.PW(16), .AW(24), .NTERMS(8)) dut (
        .clk(clk), .rst(rst),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data), .prod_last(prod_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_count(res_count), .res_ovf(res_ovf)
    );

    wallace_dot_accum #(.PW(16), .AW(16), .NTERMS(2)) dut_narrow (
        .clk(clk), .rst(rst),
        .prod_valid(p2_valid), .prod_ready(p2_ready), .prod_data(p2_data), .prod_last(p2_last),
        .res_valid(r2_valid), .res_ready(r2_ready), .res_data(r2_data), .res_count(r2_count), .res_ovf(r2_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (res_valid && res_ready) hs++;
    end

    typedef struct {
        int               n;
        logic [7:0][15:0] t;
        bit               use_last;
        logic [23:0]      exp_data;
        logic [3:0]       exp_cnt;
    } vec_t;

    vec_t vecs[6];

`ifdef WALLACE_ACC_SAT_EN
    localparam logic [15:0] NARROW_EXP = 16'hFFFF;
`else
    localparam logic [15:0] NARROW_EXP = 16'hFC02;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic last);
        @(negedge clk);
        prod_valid = 1'b1;
        prod_data  = d;
        prod_last  = last;
    endtask

    task automatic checkResult(input string name, input logic [23:0] d, input logic [3:0] c);
        checkOutput({name, "_valid"}, 32'(res_valid), 32'd1);
        checkOutput({name, "_data"}, 32'(res_data), 32'(d));
        checkOutput({name, "_count"}, 32'(res_count), 32'(c));
        checkOutput({name, "_ready_low"}, 32'(prod_ready), 32'd0);
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput({name, "_valid_drop"}, 32'(res_valid), 32'd0);
        checkOutput({name, "_ready_back"}, 32'(prod_ready), 32'd1);
    endtask

    initial begin
        int hs0;

        vecs[0].n = 8; vecs[0].use_last = 0; vecs[0].exp_data = 24'h07F008; vecs[0].exp_cnt = 4'd8;
        for (int k = 0; k < 8; k++) vecs[0].t[k] = 16'd65025;
        vecs[1].n = 3; vecs[1].use_last = 1; vecs[1].exp_data = 24'd6; vecs[1].exp_cnt = 4'd3;
        for (int k = 0; k < 8; k++) vecs[1].t[k] = 16'(k + 1);
        vecs[2].n = 1; vecs[2].use_last = 1; vecs[2].exp_data = 24'h00FFFF; vecs[2].exp_cnt = 4'd1;
        for (int k = 0; k < 8; k++) vecs[2].t[k] = 16'hFFFF;
        vecs[3].n = 8; vecs[3].use_last = 1; vecs[3].exp_data = 24'd36; vecs[3].exp_cnt = 4'd8;
        for (int k = 0; k < 8; k++) vecs[3].t[k] = 16'(k + 1);
        vecs[4].n = 2; vecs[4].use_last = 1; vecs[4].exp_data = 24'h001235; vecs[4].exp_cnt = 4'd2;
        vecs[4].t = '0; vecs[4].t[0] = 16'h1234; vecs[4].t[1] = 16'h0001;
        vecs[5].n = 5; vecs[5].use_last = 1; vecs[5].exp_data = 24'd0; vecs[5].exp_cnt = 4'd5;
        vecs[5].t = '0;

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_res_count", 32'(res_count), 32'd0);
        checkOutput("rst_res_ovf", 32'(res_ovf), 32'd0);
        checkOutput("rst_prod_ready", 32'(prod_ready), 32'd1);
        checkOutput("rst_narrow_ready", 32'(p2_ready), 32'd1);

        // Table-driven results, back-to-back terms, one-cycle latency after the closing term.
        for (int i = 0; i < 6; i++) begin
            hs0 = hs;
            for (int k = 0; k < vecs[i].n; k++)
                applyStimulus(vecs[i].t[k], vecs[i].use_last && (k == vecs[i].n - 1));
            @(negedge clk);
            prod_valid = 1'b0;
            prod_last  = 1'b0;
            checkResult($sformatf("v%0d", i), vecs[i].exp_data, vecs[i].exp_cnt);
            checkOutput($sformatf("v%0d_ovf", i), 32'(res_ovf), 32'd0);
            handshake($sformatf("v%0d", i));
            checkOutput($sformatf("v%0d_one_result", i), 32'(hs - hs0), 32'd1);
        end

        // Backpressure: result holds, junk terms ignored, next term accepted right after the handshake.
        applyStimulus(16'd10, 1'b0);
        applyStimulus(16'd20, 1'b1);
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        checkResult("bp_first", 24'd30, 4'd2);
        for (int k = 0; k < 5; k++) begin
            prod_valid = 1'b1;
            prod_data  = 16'h5555;
            prod_last  = 1'b1;
            @(negedge clk);
            checkResult($sformatf("bp_hold%0d", k), 24'd30, 4'd2);
        end
        res_ready = 1'b1;
        prod_data = 16'd7;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("bp_valid_drop", 32'(res_valid), 32'd0);
        checkOutput("bp_ready_back", 32'(prod_ready), 32'd1);
        @(negedge clk);
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        checkResult("bp_next", 24'd7, 4'd1);
        handshake("bp_next");

        // Reset mid-accumulation discards the partial sum.
        hs0 = hs;
        for (int k = 0; k < 4; k++) applyStimulus(16'd100, 1'b0);
        @(negedge clk);
        prod_valid = 1'b0;
        rst = 1'b1;
        checkOutput("mid_no_early_result", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(res_data), 32'd0);
        checkOutput("mid_rst_count", 32'(res_count), 32'd0);
        checkOutput("mid_rst_ready", 32'(prod_ready), 32'd1);
        for (int k = 0; k < 8; k++) applyStimulus(16'd1, 1'b0);
        @(negedge clk);
        prod_valid = 1'b0;
        checkResult("mid_after", 24'd8, 4'd8);
        handshake("mid_after");
        checkOutput("mid_one_result", 32'(hs - hs0), 32'd1);

        // Random bubbles between terms.
        hs0 = hs;
        for (int k = 0; k < 8; k++) begin
            while ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                prod_valid = 1'b0;
                checkOutput($sformatf("bub_no_early%0d", k), 32'(res_valid), 32'd0);
            end
            applyStimulus(16'd3, 1'b0);
        end
        @(negedge clk);
        prod_valid = 1'b0;
        checkResult("bub", 24'd24, 4'd8);
        handshake("bub");
        repeat (5) @(negedge clk);
        checkOutput("bub_no_second", 32'(res_valid), 32'd0);
        checkOutput("bub_one_result", 32'(hs - hs0), 32'd1);

        // Narrow instance: carry out of the top bit, then ovf cleared on the next result.
        @(negedge clk);
        p2_valid = 1'b1;
        p2_data  = 16'd65025;
        @(negedge clk);
        @(negedge clk);
        p2_valid = 1'b0;
        checkOutput("ovf_valid", 32'(r2_valid), 32'd1);
        checkOutput("ovf_data", 32'(r2_data), 32'(NARROW_EXP));
        checkOutput("ovf_count", 32'(r2_count), 32'd2);
        checkOutput("ovf_flag", 32'(r2_ovf), 32'd1);
        r2_ready = 1'b1;
        @(negedge clk);
        r2_ready = 1'b0;
        p2_valid = 1'b1;
        p2_data  = 16'd1;
        @(negedge clk);
        p2_data  = 16'd2;
        @(negedge clk);
        p2_valid = 1'b0;
        checkOutput("ovf_next_data", 32'(r2_data), 32'd3);
        checkOutput("ovf_next_flag", 32'(r2_ovf), 32'd0);
        r2_ready = 1'b1;
        @(negedge clk);
        r2_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
